// File: rtl/cycle_counter_reader.sv
// ---------------------------------------------------------------------------
// cycle_counter_reader
//
// Purpose:
//   Read port onto a free-running 32-bit cycle counter. Tracks wraps of the
//   incoming count to build a 64-bit HIGH:LOW view. Also offers a DELTA
//   register that returns the cycles elapsed since the last LOW read.
//   Reads use a valid/ready request and a valid/ready response. At most one
//   read is in flight.
//
// Ports:
//   clk        in   1   clock, all state updates on the rising edge
//   rst_n      in   1   asynchronous active-low reset
//   hc_in      in  32   free-running cycle count (wraps FFFFFFFF -> 0)
//   req_valid  in   1   read request present
//   req_addr   in   2   0 = LOW, 1 = HIGH, 2 = DELTA, 3 = invalid
//   req_ready  out  1   block can accept a request (IDLE)
//   rsp_valid  out  1   response held on rsp_data/rsp_err (RESP)
//   rsp_data   out 32   read data
//   rsp_err    out  1   invalid address flag
//   rsp_ready  in   1   consumer accepts the response
//
// Configuration:
//   CYCLE_SNAPSHOT_EN  When defined, a LOW read also latches the matching
//                      high word into shadow_hi. HIGH reads then return
//                      shadow_hi, which makes a LOW-then-HIGH pair atomic.
//                      When undefined, HIGH returns the live high word.
// ---------------------------------------------------------------------------
module cycle_counter_reader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] hc_in,
  input  logic        req_valid,
  input  logic [1:0]  req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        rsp_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] hc_prev;
  logic [31:0] wrap_cnt;
  logic [31:0] last_low;
  logic        wrap_now;
  logic [31:0] live_hi;
  logic        accept;
  logic [31:0] high_src;
  logic [31:0] rd_data;
  logic        rd_err;

`ifdef CYCLE_SNAPSHOT_EN
  logic [31:0] shadow_hi;
`endif

  // The count only ever moves forward by one, so a smaller value than last
  // cycle means it rolled over. The live high word already includes this
  // cycle's wrap, so HIGH:LOW stays consistent in the wrap cycle itself.
  assign wrap_now = (hc_in < hc_prev);
  assign live_hi  = wrap_cnt + {31'd0, wrap_now};
  assign accept   = req_valid && req_ready;

  // Wrap tracking runs every cycle, whatever the handshake is doing. After
  // reset hc_prev is zero, and no unsigned count is below zero, so the first
  // cycle after release can never report a spurious wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_prev  <= 32'd0;
      wrap_cnt <= 32'd0;
    end else begin
      hc_prev <= hc_in;
      if (wrap_now) begin
        wrap_cnt <= wrap_cnt + 32'd1;
      end
    end
  end

  // State register for the two-state handshake FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // IDLE accepts one request and moves to RESP. RESP holds the response
  // until the consumer takes it, then returns to IDLE. A new request is
  // never accepted in the same cycle, so back-to-back reads take two cycles.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Source of the HIGH register: the snapshot taken by the last LOW read, or
  // the live high word.
  always_comb begin
`ifdef CYCLE_SNAPSHOT_EN
    high_src = shadow_hi;
`else
    high_src = live_hi;
`endif
  end

  // Read mux. All values come from the current cycle's hc_in, so the data
  // reflects the cycle in which the request is accepted.
  always_comb begin
    rd_data = 32'd0;
    rd_err  = 1'b0;
    case (req_addr)
      2'd0:    rd_data = hc_in;
      2'd1:    rd_data = high_src;
      2'd2:    rd_data = hc_in - last_low;
      default: rd_err  = 1'b1;
    endcase
  end

  // Capture the response on accept and hold it unchanged until the next
  // accept. This keeps rsp_data/rsp_err stable while the consumer stalls.
  // Only LOW reads move last_low, which is the reference point for DELTA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= 32'd0;
      rsp_err  <= 1'b0;
      last_low <= 32'd0;
    end else if (accept) begin
      rsp_data <= rd_data;
      rsp_err  <= rd_err;
      if (req_addr == 2'd0) begin
        last_low <= hc_in;
      end
    end
  end

`ifdef CYCLE_SNAPSHOT_EN
  // A LOW read freezes the matching high word. A later HIGH read then pairs
  // with that LOW value even if the counter has wrapped in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_hi <= 32'd0;
    end else if (accept && (req_addr == 2'd0)) begin
      shadow_hi <= live_hi;
    end
  end
`endif

endmodule
